wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter CNT_W, default 64: width of the retire counter.
REQ-002 Parameter RST_PC, default 32'h8000_0000: retire_pc value held while in reset.
REQ-003 clock  in  1  clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  the upstream (memory) stage presents an instruction.
REQ-006 in_ready  out  1  wb_stage accepts the instruction; a transfer occurs when in_valid and in_ready are both 1.
REQ-007 in_pc, in_inst  in  32 each  PC and encoding of the instruction.
REQ-008 in_rd  in  5  destination register; in_rd_wen  in  1  the instruction writes in_rd.
REQ-009 in_sel  in  2  result source: 0 ALU, 1 MEM, 2 PC+4, 3 CSR.
REQ-010 in_alu_result, in_csr_rdata  in  32 each  ALU result and CSR read data.
REQ-011 in_mem_op  in  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
REQ-012 in_addr_lo  in  2  load address bits [1:0].
REQ-013 mem_rvalid  in  1  load data is valid this cycle; mem_rdata  in  32  raw aligned data word.
REQ-014 rf_wen  out  1, rf_waddr  out  5, rf_wdata  out  32: register-file write port.
REQ-015 fwd_valid  out  1, fwd_rd  out  5, fwd_data  out  32: bypass to decode, valid only when the write is final.
REQ-016 retire_valid  out  1, retire_pc  out  32, retire_inst  out  32, retire_cnt  out  CNT_W: commit record.

Function
REQ-017 States: IDLE, WAIT_MEM, COMMIT; in_ready SHALL be 1 only in IDLE, or in COMMIT (back-to-back acceptance).
REQ-018 On transfer with in_sel!=1, or with in_sel==1 and mem_rvalid=1 in the same cycle, the instruction is latched and the next state is COMMIT.
REQ-019 On transfer with in_sel==1 and mem_rvalid=0, the next state is WAIT_MEM; the first mem_rvalid=1 latches mem_rdata and moves the FSM to COMMIT.
REQ-020 Load extraction: byte/half is selected by in_addr_lo, then sign-extended (LB, LH) or zero-extended (LBU, LHU); LW uses the whole word; LH/LHU with in_addr_lo=3 uses bits [31:16] of the word (misalignment is undefined upstream and is not trapped).
REQ-021 PC+4 is computed modulo 2^32: pc 32'hFFFF_FFFC yields 0.
REQ-022 In COMMIT for exactly one cycle: retire_valid=1 and rf_wen=in_rd_wen&&(rd!=0); rf_wdata = the selected result; fwd_valid=rf_wen.
REQ-023 rd=0 with wen=1: rf_wen=0 and fwd_valid=0, but the instruction still retires.
REQ-024 retire_cnt increments by 1 on every retire_valid cycle and wraps to 0 at all-ones.
REQ-025 Latency: a non-load instruction, or a load with data ready at transfer, retires in the cycle after its transfer; a waiting load retires in the cycle after mem_rvalid.
REQ-026 COMMIT with no in_valid returns the FSM to IDLE; with in_valid, the new instruction transfers in the same cycle (REQ-018/019 apply).
REQ-027 mem_rvalid outside WAIT_MEM (other than at a load transfer) is ignored.

Reset
REQ-028 While reset=1: FSM=IDLE; in_ready=1; rf_wen, fwd_valid and retire_valid are 0; retire_cnt=0; retire_pc=RST_PC; all other outputs 0.
REQ-029 Reset asserted in WAIT_MEM discards the pending load: no write occurs, and no retire occurs after reset is released.

Configuration
REQ-030 With macro WB_TRACE_EN defined, each retire prints through $display: pc, inst, and (if rf_wen) waddr and wdata.
REQ-031 Without WB_TRACE_EN, no simulation output is generated, and logic and timing are unchanged.

Structure
REQ-032 Package npc_pkg: result-select enum (SEL_ALU, SEL_MEM, SEL_PC4, SEL_CSR), load-op enum, WB FSM state enum, and the RST_PC constant.
REQ-033 One sub-module, load_align: combinational; inputs mem_op, addr_lo and rdata; output the 32-bit extended value.

Verification
REQ-034 ALU: rd=5, wen=1, alu=32'h1234_5678 -> next cycle rf_wen=1, waddr=5, wdata=32'h1234_5678, retire_cnt=1.
REQ-035 LB with addr_lo=3, rdata=32'h80FF_FFFF and mem_rvalid 3 cycles late -> in_ready=0 for 3 cycles, then wdata=32'hFFFF_FF80.
REQ-036 LHU with addr_lo=2, rdata=32'h8001_0000 -> wdata=32'h0000_8001; LW -> wdata=32'h8001_0000.
REQ-037 rd=0, wen=1, sel=PC4, pc=32'hFFFF_FFFC -> rf_wen=0, retire_valid=1, retire_pc=32'hFFFF_FFFC.
REQ-038 4 back-to-back ALU instructions with in_valid held high -> one retire per cycle, and retire_cnt goes 1, 2, 3, 4.
REQ-039 Reset asserted during WAIT_MEM, then mem_rvalid=1 after release -> no rf_wen, no retire_valid, and retire_cnt=0.

Source files
------------

// File: rtl/npc_pkg.sv
// npc_pkg: shared types and constants for the writeback stage.
//   wb_sel_e   : result source select (ALU, MEM, PC+4, CSR)
//   load_op_e  : load type encoding (LB, LH, LW, LBU, LHU)
//   wb_state_e : writeback FSM states
//   RST_PC     : retire_pc value held while in reset
//   pc_plus4() : link address, wraps modulo 2^32
package npc_pkg;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        SEL_ALU = 2'd0,
        SEL_MEM = 2'd1,
        SEL_PC4 = 2'd2,
        SEL_CSR = 2'd3
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'd0,
        LD_LH  = 3'd1,
        LD_LW  = 3'd2,
        LD_LBU = 3'd4,
        LD_LHU = 3'd5
    } load_op_e;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_WAIT_MEM = 2'd1,
        WB_COMMIT   = 2'd2
    } wb_state_e;

    // 32-bit addition drops the carry, so 32'hFFFF_FFFC + 4 gives 0.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: combinational load data extraction.
//   mem_op  in  3  load type (load_op_e encoding)
//   addr_lo in  2  byte offset of the load inside the word
//   rdata   in  32 raw aligned data word from memory
//   data    out 32 selected byte/half/word, sign- or zero-extended
// A halfword at offset 3 is misaligned; it takes bits [31:16] because only
// addr_lo[1] picks the half. Unknown op codes pass the whole word through.
module load_align
    import npc_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte lane select by address offset
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
    end

    // Half lane select by address bit 1
    always_comb begin
        half_s = 16'h0000;
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extension according to load type
    always_comb begin
        data = rdata;
        case (load_op_e'(mem_op))
            LD_LB:   data = {{24{byte_s[7]}}, byte_s};
            LD_LH:   data = {{16{half_s[15]}}, half_s};
            LD_LW:   data = rdata;
            LD_LBU:  data = {24'h00_0000, byte_s};
            LD_LHU:  data = {16'h0000, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback / commit stage.
// Accepts one instruction from the memory stage, waits for load data if it
// is not ready, then spends exactly one COMMIT cycle presenting the
// register-file write, the decode bypass and the retire record. All outputs
// come straight from flops.
//   clock, reset               clock and asynchronous active-high reset
//   in_valid / in_ready        upstream handshake
//   in_pc, in_inst, in_rd, in_rd_wen, in_sel, in_alu_result, in_csr_rdata,
//   in_mem_op, in_addr_lo      instruction fields
//   mem_rvalid, mem_rdata      load data return
//   rf_wen, rf_waddr, rf_wdata register-file write port
//   fwd_valid, fwd_rd, fwd_data bypass to decode
//   retire_valid, retire_pc, retire_inst, retire_cnt  commit record
// Optional macro WB_TRACE_EN: prints every retire through $display.
module wb_stage #(
    parameter int          CNT_W  = 64,
    parameter logic [31:0] RST_PC = npc_pkg::RST_PC
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    input  logic [4:0]       in_rd,
    input  logic             in_rd_wen,
    input  logic [1:0]       in_sel,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_csr_rdata,
    input  logic [2:0]       in_mem_op,
    input  logic [1:0]       in_addr_lo,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             rf_wen,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [31:0]      fwd_data,
    output logic             retire_valid,
    output logic [31:0]      retire_pc,
    output logic [31:0]      retire_inst,
    output logic [CNT_W-1:0] retire_cnt
);

    import npc_pkg::*;

    wb_state_e        state_r;
    wb_state_e        state_s;
    logic             in_ready_r;

    // Instruction parked while its load data is outstanding
    logic [31:0]      hold_pc_r;
    logic [31:0]      hold_inst_r;
    logic [4:0]       hold_rd_r;
    logic             hold_wen_r;
    logic [2:0]       hold_op_r;
    logic [1:0]       hold_addr_r;

    logic             commit_s;
    logic             park_s;
    logic [31:0]      cm_pc_s;
    logic [31:0]      cm_inst_s;
    logic [4:0]       cm_rd_s;
    logic             cm_wen_s;
    logic [31:0]      cm_data_s;

    logic [2:0]       align_op_s;
    logic [1:0]       align_addr_s;
    logic [31:0]      align_data_s;

    logic             rf_wen_r;
    logic [4:0]       rf_waddr_r;
    logic [31:0]      rf_wdata_r;
    logic             retire_valid_r;
    logic [31:0]      retire_pc_r;
    logic [31:0]      retire_inst_r;
    logic [CNT_W-1:0] retire_cnt_r;

    logic             sel_mem_s;

    assign sel_mem_s = (wb_sel_e'(in_sel) == SEL_MEM);

    // Next state: accept in IDLE or COMMIT, park a load whose data is late
    always_comb begin
        state_s  = state_r;
        commit_s = 1'b0;
        park_s   = 1'b0;
        case (state_r)
            WB_IDLE, WB_COMMIT: begin
                if (in_valid) begin
                    if (sel_mem_s && !mem_rvalid) begin
                        state_s = WB_WAIT_MEM;
                        park_s  = 1'b1;
                    end else begin
                        state_s  = WB_COMMIT;
                        commit_s = 1'b1;
                    end
                end else begin
                    state_s = WB_IDLE;
                end
            end
            WB_WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_s  = WB_COMMIT;
                    commit_s = 1'b1;
                end else begin
                    state_s = WB_WAIT_MEM;
                end
            end
            default: begin
                state_s = WB_IDLE;
            end
        endcase
    end

    // Load aligner sees the parked load while waiting, else the live one
    always_comb begin
        align_op_s   = in_mem_op;
        align_addr_s = in_addr_lo;
        if (state_r == WB_WAIT_MEM) begin
            align_op_s   = hold_op_r;
            align_addr_s = hold_addr_r;
        end else begin
            align_op_s   = in_mem_op;
            align_addr_s = in_addr_lo;
        end
    end

    load_align u_load_align (
        .mem_op  (align_op_s),
        .addr_lo (align_addr_s),
        .rdata   (mem_rdata),
        .data    (align_data_s)
    );

    // Commit record source: parked load, or the instruction transferring now
    always_comb begin
        cm_pc_s   = in_pc;
        cm_inst_s = in_inst;
        cm_rd_s   = in_rd;
        cm_wen_s  = in_rd_wen;
        cm_data_s = in_alu_result;
        if (state_r == WB_WAIT_MEM) begin
            cm_pc_s   = hold_pc_r;
            cm_inst_s = hold_inst_r;
            cm_rd_s   = hold_rd_r;
            cm_wen_s  = hold_wen_r;
            cm_data_s = align_data_s;
        end else begin
            case (wb_sel_e'(in_sel))
                SEL_ALU: cm_data_s = in_alu_result;
                SEL_MEM: cm_data_s = align_data_s;
                SEL_PC4: cm_data_s = pc_plus4(in_pc);
                SEL_CSR: cm_data_s = in_csr_rdata;
                default: cm_data_s = in_alu_result;
            endcase
        end
    end

    // FSM state and registered ready flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= WB_IDLE;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s != WB_WAIT_MEM);
        end
    end

    // Park the fields of a load waiting for its data
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_pc_r   <= 32'h0000_0000;
            hold_inst_r <= 32'h0000_0000;
            hold_rd_r   <= 5'd0;
            hold_wen_r  <= 1'b0;
            hold_op_r   <= 3'd0;
            hold_addr_r <= 2'd0;
        end else if (park_s) begin
            hold_pc_r   <= in_pc;
            hold_inst_r <= in_inst;
            hold_rd_r   <= in_rd;
            hold_wen_r  <= in_rd_wen;
            hold_op_r   <= in_mem_op;
            hold_addr_r <= in_addr_lo;
        end
    end

    // Commit outputs: one-cycle strobes, data fields hold between commits
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_wen_r       <= 1'b0;
            rf_waddr_r     <= 5'd0;
            rf_wdata_r     <= 32'h0000_0000;
            retire_valid_r <= 1'b0;
            retire_pc_r    <= RST_PC;
            retire_inst_r  <= 32'h0000_0000;
            retire_cnt_r   <= {CNT_W{1'b0}};
        end else if (commit_s) begin
            rf_wen_r       <= cm_wen_s && (cm_rd_s != 5'd0);
            rf_waddr_r     <= cm_rd_s;
            rf_wdata_r     <= cm_data_s;
            retire_valid_r <= 1'b1;
            retire_pc_r    <= cm_pc_s;
            retire_inst_r  <= cm_inst_s;
            retire_cnt_r   <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            rf_wen_r       <= 1'b0;
            retire_valid_r <= 1'b0;
        end
    end

    assign in_ready     = in_ready_r;
    assign rf_wen       = rf_wen_r;
    assign rf_waddr     = rf_waddr_r;
    assign rf_wdata     = rf_wdata_r;
    // The write is final in COMMIT, so the bypass mirrors the write port
    assign fwd_valid    = rf_wen_r;
    assign fwd_rd       = rf_waddr_r;
    assign fwd_data     = rf_wdata_r;
    assign retire_valid = retire_valid_r;
    assign retire_pc    = retire_pc_r;
    assign retire_inst  = retire_inst_r;
    assign retire_cnt   = retire_cnt_r;

`ifdef WB_TRACE_EN
    // Retire trace
    always_ff @(posedge clock) begin
        if (retire_valid_r) begin
            if (rf_wen_r) begin
                $display("wb retire pc=%08h inst=%08h x%0d=%08h",
                         retire_pc_r, retire_inst_r, rf_waddr_r, rf_wdata_r);
            end else begin
                $display("wb retire pc=%08h inst=%08h", retire_pc_r, retire_inst_r);
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed scenarios plus randomized traffic against a
// behavioural model of the writeback stage.
module tb_wb_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = 32'h0, in_inst = 32'h0;
    logic [4:0]  in_rd = 5'd0;
    logic        in_rd_wen = 1'b0;
    logic [1:0]  in_sel = 2'd0;
    logic [31:0] in_alu_result = 32'h0, in_csr_rdata = 32'h0;
    logic [2:0]  in_mem_op = 3'd0;
    logic [1:0]  in_addr_lo = 2'd0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        rf_wen, fwd_valid, retire_valid;
    logic [4:0]  rf_waddr, fwd_rd;
    logic [31:0] rf_wdata, fwd_data, retire_pc, retire_inst;
    logic [63:0] retire_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clock = ~clock;

    wb_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .in_sel(in_sel), .in_alu_result(in_alu_result), .in_csr_rdata(in_csr_rdata),
        .in_mem_op(in_mem_op), .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_inst(retire_inst), .retire_cnt(retire_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Load extraction from the rules: shift the wanted lane down, then extend
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] w);
        int sh;
        logic [31:0] v;
        if (op == 3'd1 || op == 3'd5) sh = a[1] ? 16 : 0;
        else                          sh = 8 * int'(a);
        v = w >> sh;
        case (op)
            3'd0:    return {{24{v[7]}}, v[7:0]};
            3'd1:    return {{16{v[15]}}, v[15:0]};
            3'd4:    return {24'h0, v[7:0]};
            3'd5:    return {16'h0, v[15:0]};
            default: return w;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    logic        m_wait;
    logic [31:0] p_pc, p_inst;
    logic [4:0]  p_rd;
    logic        p_wen;
    logic [2:0]  p_op;
    logic [1:0]  p_addr;
    logic        m_rv, m_rfwen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata, m_rpc, m_rinst;
    logic [63:0] m_cnt;
    logic        t_go, t_wen;
    logic [31:0] t_pc, t_inst, t_res;
    logic [4:0]  t_rd;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_wait <= 1'b0; m_rv <= 1'b0; m_rfwen <= 1'b0; m_waddr <= 5'd0;
            m_wdata <= 32'h0; m_rpc <= 32'h8000_0000; m_rinst <= 32'h0; m_cnt <= 64'd0;
        end else begin
            t_go = 1'b0; t_pc = 32'h0; t_inst = 32'h0; t_rd = 5'd0; t_wen = 1'b0; t_res = 32'h0;
            if (!m_wait) begin
                if (in_valid) begin
                    if (in_sel == 2'd1 && !mem_rvalid) begin
                        m_wait <= 1'b1;
                        p_pc <= in_pc; p_inst <= in_inst; p_rd <= in_rd;
                        p_wen <= in_rd_wen; p_op <= in_mem_op; p_addr <= in_addr_lo;
                    end else begin
                        t_go = 1'b1; t_pc = in_pc; t_inst = in_inst;
                        t_rd = in_rd; t_wen = in_rd_wen;
                        case (in_sel)
                            2'd0:    t_res = in_alu_result;
                            2'd1:    t_res = ref_load(in_mem_op, in_addr_lo, mem_rdata);
                            2'd2:    t_res = in_pc + 32'd4;
                            default: t_res = in_csr_rdata;
                        endcase
                    end
                end
            end else if (mem_rvalid) begin
                m_wait <= 1'b0;
                t_go = 1'b1; t_pc = p_pc; t_inst = p_inst; t_rd = p_rd; t_wen = p_wen;
                t_res = ref_load(p_op, p_addr, mem_rdata);
            end
            m_rv    <= t_go;
            m_rfwen <= t_go && t_wen && (t_rd != 5'd0);
            if (t_go) begin
                m_waddr <= t_rd; m_wdata <= t_res; m_rpc <= t_pc;
                m_rinst <= t_inst; m_cnt <= m_cnt + 64'd1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("in_ready", in_ready, !m_wait);
            chk("retire_valid", retire_valid, m_rv);
            chk("rf_wen", rf_wen, m_rfwen);
            chk("fwd_valid", fwd_valid, m_rfwen);
            chk("retire_cnt", retire_cnt, m_cnt);
            chk("retire_pc", retire_pc, m_rpc);
            if (m_rv || reset) begin
                chk("rf_wdata", rf_wdata, m_wdata);
                chk("retire_inst", retire_inst, m_rinst);
            end
            if (m_rfwen || reset) begin
                chk("rf_waddr", rf_waddr, m_waddr);
                chk("fwd_rd", fwd_rd, m_waddr);
                chk("fwd_data", fwd_data, m_wdata);
            end
        end
    end

    task automatic idle();
        in_valid = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic put(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                       input logic [1:0] sel, input logic [31:0] alu, input logic [2:0] op,
                       input logic [1:0] addr, input logic rv, input logic [31:0] rdata);
        in_valid = 1'b1; in_pc = pc; in_inst = pc ^ 32'h0000_0013; in_rd = rd;
        in_rd_wen = wen; in_sel = sel; in_alu_result = alu; in_csr_rdata = ~alu;
        in_mem_op = op; in_addr_lo = addr; mem_rvalid = rv; mem_rdata = rdata;
    endtask

    task automatic do_reset();
        @(posedge clock); #1; reset = 1'b1; idle();
        @(negedge clock);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_retire_valid", retire_valid, 1'b0);
        chk("rst_rf_wen", rf_wen, 1'b0);
        chk("rst_fwd_valid", fwd_valid, 1'b0);
        chk("rst_retire_cnt", retire_cnt, 64'd0);
        chk("rst_retire_pc", retire_pc, 32'h8000_0000);
        chk("rst_rf_wdata", rf_wdata, 32'h0);
        chk("rst_retire_inst", retire_inst, 32'h0);
        @(posedge clock); #1; reset = 1'b0;
    endtask

    initial begin
        @(posedge clock); #1; cmp_en = 1'b1;
        do_reset();

        // ALU write to x5
        put(32'h0000_0100, 5'd5, 1'b1, 2'd0, 32'h1234_5678, 3'd0, 2'd0, 1'b0, 32'h0);
        @(posedge clock); #1; idle();
        @(negedge clock);
        chk("alu_rf_wen", rf_wen, 1'b1);
        chk("alu_waddr", rf_waddr, 5'd5);
        chk("alu_wdata", rf_wdata, 32'h1234_5678);
        chk("alu_cnt", retire_cnt, 64'd1);

        // LB at offset 3, data three cycles late
        @(posedge clock); #1;
        put(32'h0000_0104, 5'd6, 1'b1, 2'd1, 32'h0BAD_0BAD, 3'd0, 2'd3, 1'b0, 32'h0);
        @(posedge clock); #1; idle(); mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin mem_rvalid = 1'b1; mem_rdata = 32'h80FF_FFFF; end
            @(negedge clock);
            chk("lb_stall_ready", in_ready, 1'b0);
            chk("lb_stall_retire", retire_valid, 1'b0);
            @(posedge clock); #1; mem_rvalid = 1'b0;
        end
        @(negedge clock);
        chk("lb_retire", retire_valid, 1'b1);
        chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);

        // LHU at offset 2 and LW, data ready at transfer
        @(posedge clock); #1;
        put(32'h0000_0108, 5'd7, 1'b1, 2'd1, 32'h0, 3'd5, 2'd2, 1'b1, 32'h8001_0000);
        @(posedge clock); #1; idle();
        @(negedge clock);
        chk("lhu_wdata", rf_wdata, 32'h0000_8001);
        @(posedge clock); #1;
        put(32'h0000_010C, 5'd8, 1'b1, 2'd1, 32'h0, 3'd2, 2'd0, 1'b1, 32'h8001_0000);
        @(posedge clock); #1; idle();
        @(negedge clock);
        chk("lw_wdata", rf_wdata, 32'h8001_0000);

        // rd=0 with PC+4 at the top of the address space
        @(posedge clock); #1;
        put(32'hFFFF_FFFC, 5'd0, 1'b1, 2'd2, 32'h5555_5555, 3'd0, 2'd0, 1'b0, 32'h0);
        @(posedge clock); #1; idle();
        @(negedge clock);
        chk("x0_rf_wen", rf_wen, 1'b0);
        chk("x0_fwd_valid", fwd_valid, 1'b0);
        chk("x0_retire", retire_valid, 1'b1);
        chk("x0_retire_pc", retire_pc, 32'hFFFF_FFFC);
        chk("x0_pc4_wrap", rf_wdata, 32'h0000_0000);

        // Four back-to-back ALU instructions
        do_reset();
        @(posedge clock); #1;
        for (int i = 0; i < 4; i++) begin
            put(32'h0000_0200 + 32'(4 * i), 5'(i + 1), 1'b1, 2'd0, 32'(i * 32'h11), 3'd0,
                2'd0, 1'b0, 32'h0);
            @(posedge clock); #1;
            if (i == 3) idle();
            @(negedge clock);
            chk("b2b_retire", retire_valid, 1'b1);
            chk("b2b_cnt", retire_cnt, 64'(i + 1));
            chk("b2b_wdata", rf_wdata, 32'(i * 32'h11));
        end

        // Reset while a load waits: the load must vanish
        do_reset();
        @(posedge clock); #1;
        put(32'h0000_0300, 5'd9, 1'b1, 2'd1, 32'h0, 3'd2, 2'd0, 1'b0, 32'h0);
        @(posedge clock); #1; idle();
        @(negedge clock);
        chk("rstw_wait_ready", in_ready, 1'b0);
        #2; reset = 1'b1;
        @(negedge clock);
        chk("rstw_in_reset_ready", in_ready, 1'b1);
        @(posedge clock); #1; reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(posedge clock); #1; mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rstw_rf_wen", rf_wen, 1'b0);
            chk("rstw_retire", retire_valid, 1'b0);
            chk("rstw_cnt", retire_cnt, 64'd0);
        end

        // Randomized traffic, occasional one-cycle reset pulses
        for (int c = 0; c < 4000; c++) begin
            @(posedge clock); #1;
            reset         = ($urandom_range(0, 299) == 0);
            in_valid      = ($urandom_range(0, 3) != 0);
            in_pc         = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if ($urandom_range(0, 15) == 0) in_pc = 32'hFFFF_FFFC;
            in_inst       = $urandom;
            in_rd         = 5'($urandom_range(0, 31));
            in_rd_wen     = 1'($urandom_range(0, 1));
            in_sel        = 2'($urandom_range(0, 3));
            in_alu_result = $urandom;
            in_csr_rdata  = $urandom;
            case ($urandom_range(0, 4))
                0:       in_mem_op = 3'd0;
                1:       in_mem_op = 3'd1;
                2:       in_mem_op = 3'd2;
                3:       in_mem_op = 3'd4;
                default: in_mem_op = 3'd5;
            endcase
            in_addr_lo    = 2'($urandom_range(0, 3));
            mem_rvalid    = ($urandom_range(0, 2) == 0);
            mem_rdata     = $urandom;
        end
        @(posedge clock); #1; reset = 1'b0; idle();
        repeat (3) @(posedge clock);
        @(negedge clock); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
